// File: rtl/apb_requester.sv
// APB requester: turns single-beat valid/ready commands into APB SETUP/ACCESS
// transfers and returns read data or a timeout error on a one-cycle strobe.
module apb_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [7:0]        tmo_cnt, tmo_cnt_nxt;
    logic              psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // The response strobe defaults low so it lasts exactly the RESP cycle.
    always_comb begin
        state_nxt     = state;
        tmo_cnt_nxt   = tmo_cnt;
        psel_nxt      = PSEL;
        penable_nxt   = PENABLE;
        pwrite_nxt    = PWRITE;
        paddr_nxt     = PADDR;
        pwdata_nxt    = PWDATA;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        cmd_ready     = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    pwrite_nxt  = cmd_write;
                    paddr_nxt   = cmd_addr;
                    pwdata_nxt  = cmd_wdata;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                tmo_cnt_nxt = '0;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over a timeout firing in the same cycle.
                if (PREADY) begin
                    rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    state_nxt     = RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    state_nxt     = RESP;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            RESP: begin
                pwrite_nxt = 1'b0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB requester (initiator) that turns single-beat commands from a local valid/ready port into APB SETUP/ACCESS transfers.
- Drives the PSEL/PENABLE/PWRITE/PADDR/PWDATA bus and samples PRDATA/PREADY from one completer, such as the subtractor register block.
- Returns read data, or a timeout error, on a one-cycle response strobe.
- Used as the bus master in block-level benches and by on-chip control logic.

Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR.
- DATA_W, 32, width of cmd_wdata, rsp_rdata, PWDATA and PRDATA.
- TIMEOUT, 16, maximum number of ACCESS cycles without PREADY before the transfer is aborted; legal range 1..255.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout abort; qualified by rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB completion.

Behaviour:
- One clock domain (PCLK). Reset is asynchronous and active-low (PRESETn).
- Reset values: state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the timeout counter all 0.
- Reset takes effect immediately, mid-transfer included: the bus drops at once and no response is issued for the aborted command.
- FSM states are IDLE, SETUP, ACCESS and RESP. Every bus output is registered.
- IDLE:
  - cmd_ready = 1; cmd_ready is 0 in every other state.
  - On cmd_valid && cmd_ready, capture cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, set PSEL = 1 and PENABLE = 0, and go to SETUP.
  - With no command, hold outputs and stay in IDLE.
- SETUP: exactly one cycle. Set PENABLE = 1, clear the timeout counter, go to ACCESS.
- ACCESS:
  - PSEL = 1 and PENABLE = 1. PADDR, PWDATA and PWRITE stay stable for the whole transfer.
  - If PREADY is sampled high: rsp_rdata <= PWRITE ? 0 : PRDATA; rsp_err <= 0; rsp_valid <= 1; PSEL <= 0; PENABLE <= 0; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 and PREADY is still low: rsp_rdata <= 0; rsp_err <= 1; rsp_valid <= 1; drop PSEL and PENABLE; go to RESP.
  - If PREADY is high in the cycle the timeout would fire, PREADY wins and the transfer completes normally.
- RESP:
  - rsp_valid is high for this single cycle; no backpressure on the response side.
  - Next state is IDLE, where rsp_valid <= 0. rsp_rdata and rsp_err hold until the next response.
- PADDR and PWDATA keep their last values after a transfer. PWRITE returns to 0 in IDLE.
- Latency:
  - Accept edge to rsp_valid = 2 + W cycles, where W is the number of ACCESS cycles with PREADY low.
  - A completer with registered PREADY gives W = 1.
  - Minimum command spacing is 4 cycles for W = 0; the next command is accepted in IDLE.
- A cmd_valid held high through a response is re-accepted on the IDLE cycle. Commands are never merged or dropped.
- PREADY and PRDATA are ignored outside ACCESS.

Test Plan:
- Subtractor completer attached: write 0x0 = 100, write 0x4 = 7, write 0x8 = 1, then read 0xC -> rsp_rdata = 93, rsp_err = 0. Every write returns rsp_valid with rsp_rdata = 0.
- Protocol check on every transfer:
  - exactly one cycle with PSEL = 1, PENABLE = 0, followed by PENABLE = 1 until PREADY;
  - PADDR and PWDATA stable from SETUP to completion;
  - no PENABLE without PSEL.
- PREADY tied 0, read 0x4 -> after exactly 16 ACCESS cycles: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; bus idle the next cycle; next command accepted.
- Completer with PREADY constant 1 and PRDATA = 0xDEADBEEF, cmd_valid held high for 3 reads -> rsp_valid on every 4th cycle, each rsp_rdata = 0xDEADBEEF.
- PRESETn pulsed low during ACCESS of a write to 0x4 = 55 -> PSEL and PENABLE go 0 asynchronously, no rsp_valid, cmd_ready = 1 after release; reading 0x4 afterwards matches the completer's real state.
- PREADY rises in cycle 16 (the TIMEOUT boundary), read 0xC with PRDATA = 0x5 -> rsp_err = 0, rsp_rdata = 0x5.
